// File: rtl/key_sender_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_sender_if
//  Description : Signal bundle for the key_sender link. Groups the local
//                controller handshake (start/code/busy/done/result), the
//                2-wire symbol link (cable1/cable2/pulsed) and the checker
//                verdict (valid_in).
//  Modports    : master - the key_sender itself (drives link and status)
//                slave  - controller / checker side (drives start, code,
//                         valid_in; observes everything else)
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_sender_if;
    logic       start;      // 1-cycle send request
    logic [7:0] code;       // access code, sampled on accepted start
    logic       busy;       // transfer in progress
    logic       done;       // 1-cycle completion pulse
    logic [1:0] result;     // 0=OK, 1=TIMEOUT, 2=ERROR
    logic       cable1;     // symbol bit 1
    logic       cable2;     // symbol bit 0
    logic       pulsed;     // symbol strobe
    logic [1:0] valid_in;   // checker verdict, asynchronous to clk

    modport master (
        input  start, code, valid_in,
        output busy, done, result, cable1, cable2, pulsed
    );

    modport slave (
        output start, code, valid_in,
        input  busy, done, result, cable1, cable2, pulsed
    );
endinterface
`default_nettype wire

// File: rtl/key_sender.sv
`default_nettype none
// ============================================================================
//  Module      : key_sender
//  Description : Transmitter end of the 2-wire key link. Sends an 8-bit code
//                as four 2-bit symbols (symbol 0 = code[1:0] first) with a
//                strobe per symbol, then waits for the checker's verdict
//                (OK=0, ERROR=2, NOKEY=3) and reports OK/TIMEOUT/ERROR.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - synchronous reset, active-low
//                bus      - key_sender_if.master (handshake, link, verdict)
//  Options     : KEY_SENDER_RETRY_EN - when defined, a first-attempt ERROR
//                or TIMEOUT silently resends the latched code once.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_sender #(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    key_sender_if.master  bus
);

    localparam int c_max_ab  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int c_max_cd  = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int c_max_all = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cnt_w   = $clog2(c_max_all) + 1;

    localparam logic [c_cnt_w-1:0] c_setup_last   = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_pulse_last   = c_cnt_w'(PULSE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last     = c_cnt_w'(GAP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_res_ok      = 2'd0;
    localparam logic [1:0] c_res_timeout = 2'd1;
    localparam logic [1:0] c_res_error   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t               state_q;
    logic [7:0]           code_q;
    logic [1:0]           sym_idx_q;
    logic [c_cnt_w-1:0]   cnt_q;
    logic [1:0]           sync0_q;
    logic [1:0]           sync1_q;
    logic                 busy_q;
    logic                 done_q;
    logic [1:0]           result_q;
    logic                 cable1_q;
    logic                 cable2_q;
    logic                 pulsed_q;

    logic [1:0]           vs;
    logic [1:0]           verdict_d;
    logic                 finish_d;
    logic                 resend_d;
    logic [1:0]           next_sym_d;

    assign vs         = sync1_q;
    assign next_sym_d = code_q[{sym_idx_q + 2'd1, 1'b0} +: 2];

    // Verdict decode while waiting; 3 (NOKEY) and the illegal 1 both mean
    // "no verdict yet" and only the timeout can end the wait.
    always_comb begin
        verdict_d = c_res_timeout;
        finish_d  = 1'b0;
        if (vs == 2'd0) begin
            verdict_d = c_res_ok;
            finish_d  = 1'b1;
        end else if (vs == 2'd2) begin
            verdict_d = c_res_error;
            finish_d  = 1'b1;
        end else if (cnt_q == c_timeout_last) begin
            finish_d  = 1'b1;
        end
    end

`ifdef KEY_SENDER_RETRY_EN
    logic retry_q;

    assign resend_d = (verdict_d != c_res_ok) && !retry_q;

    // Remembers that the single allowed resend has been used.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retry_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            retry_q <= 1'b0;
        end else if (state_q == ST_WAIT && finish_d && resend_d) begin
            retry_q <= 1'b1;
        end
    end
`else
    assign resend_d = 1'b0;
`endif

    // Verdict synchroniser; idles at NOKEY so reset never looks like OK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0_q <= 2'b11;
            sync1_q <= 2'b11;
        end else begin
            sync0_q <= bus.valid_in;
            sync1_q <= sync0_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            sym_idx_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= c_res_ok;
            cable1_q  <= 1'b0;
            cable2_q  <= 1'b0;
            pulsed_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // The done cycle is still treated as part of the transfer.
                    if (bus.start && !done_q) begin
                        code_q    <= bus.code;
                        sym_idx_q <= 2'd0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        cable1_q  <= bus.code[1];
                        cable2_q  <= bus.code[0];
                        state_q   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == c_setup_last) begin
                        cnt_q    <= '0;
                        pulsed_q <= 1'b1;
                        state_q  <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == c_pulse_last) begin
                        cnt_q    <= '0;
                        pulsed_q <= 1'b0;
                        state_q  <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == c_gap_last) begin
                        cnt_q <= '0;
                        if (sym_idx_q != 2'd3) begin
                            sym_idx_q <= sym_idx_q + 2'd1;
                            cable1_q  <= next_sym_d[1];
                            cable2_q  <= next_sym_d[0];
                            state_q   <= ST_SETUP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (finish_d && resend_d) begin
                        // Second attempt: restart from symbol 0, stay busy.
                        cnt_q     <= '0;
                        sym_idx_q <= 2'd0;
                        cable1_q  <= code_q[1];
                        cable2_q  <= code_q[0];
                        state_q   <= ST_SETUP;
                    end else if (finish_d) begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        result_q <= verdict_d;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cable1 = cable1_q;
    assign bus.cable2 = cable2_q;
    assign bus.pulsed = pulsed_q;

endmodule
`default_nettype wire

// File: doc/key_sender.md
Name: key_sender

Overview:
- Transmitter end of the alarm's 2-wire key link: serialises an 8-bit access code as four 2-bit symbols on cable1/cable2, with a strobe on pulsed per symbol.
- Waits for the remote checker's 2-bit verdict and reports the outcome to the local controller (keypad/remote side).
- Symbol order and verdict encoding match the existing key checker: symbol 0 = code[1:0] first; OK=0, ERROR=2, NOKEY=3.

Parameters:
SETUP_CYC, 2, clk cycles cable1/cable2 are held stable before pulsed rises (>=1)
PULSE_CYC, 4, clk cycles pulsed stays high (>=1)
GAP_CYC, 4, clk cycles pulsed stays low after each pulse, cables still held (>=1)
TIMEOUT_CYC, 64, clk cycles allowed for a final verdict after the 4th pulse falls (>=4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  1-cycle request to send code; ignored while busy=1
code  in  8  access code; sampled only in the cycle start is accepted
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse, result valid in the same cycle
result  out  2  0=OK, 1=TIMEOUT, 2=ERROR; held until the next done
cable1  out  1  symbol bit 1 (code[2k+1])
cable2  out  1  symbol bit 0 (code[2k])
pulsed  out  1  symbol strobe, registered, glitch-free
valid_in  in  2  verdict from checker; asynchronous to clk

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy=0, done=0, result=0, cable1=0, cable2=0, pulsed=0, sym_idx=0, counters=0, synchroniser flops=2'b11. Reset mid-transfer aborts immediately; no done is issued.
- valid_in passes through a 2-flop synchroniser; the FSM uses only the synchronised value (vs).
- FSM:
  IDLE: start=1 -> latch code, sym_idx=0, busy=1, drive symbol 0 -> SETUP.
  SETUP: hold SETUP_CYC cycles -> PULSE with pulsed=1.
  PULSE: hold PULSE_CYC cycles -> pulsed=0 -> GAP.
  GAP: hold GAP_CYC cycles; if sym_idx<3: sym_idx+1, drive next symbol -> SETUP; else -> WAIT_RESP with timeout counter=0.
  WAIT_RESP: each cycle, vs==0 -> result=OK; vs==2 -> result=ERROR; counter reaching TIMEOUT_CYC-1 with vs still 3 (or 1) -> result=TIMEOUT. On any exit: done=1 for one cycle, busy=0 -> IDLE.
- Cables change only on entry to SETUP, never while pulsed=1. They hold the last symbol after completion until the next transfer.
- Unoptional latency per symbol: SETUP_CYC+PULSE_CYC+GAP_CYC cycles. Defaults give 40 cycles for all four symbols.
- vs==1 is illegal from the checker and is treated as no verdict (keeps waiting).
- start while busy: dropped, no effect on the latched code.
- start in the same cycle as done: ignored. The FSM is IDLE only on the following cycle.
- Counters are sized $clog2(max param)+1; no wrap is possible before they are compared.

Optional Feature:
KEY_SENDER_RETRY_EN:
- Defined: on a first-attempt ERROR or TIMEOUT, the block silently resends the same latched code once, restarting at SETUP with symbol 0. busy stays high and no done is issued for the first attempt. result and done reflect the second attempt only.
- Undefined: a single attempt only, as above.

Test Plan:
- Defaults, code=8'hB4, checker model replies OK -> symbols (c1,c2)=00,01,11,10 in order. Each symbol is stable 2 cycles before pulsed rises; pulsed is high 4 cycles. done pulses with result=0 once vs=0.
- Checker model replies 2 after the 4th pulse -> result=2, done one cycle, busy falls in the same cycle.
- valid_in stuck at 3 -> done exactly TIMEOUT_CYC cycles (+ synchroniser) after the 4th pulse falls, result=1.
- start pulsed at cycle 10 of a transfer with code=8'hFF -> ignored; the original code completes unchanged.
- rst_n=0 during the 2nd PULSE -> next cycle pulsed=0, busy=0, cables=0, no done. A new start then sends all four symbols from symbol 0.
- KEY_SENDER_RETRY_EN defined, checker returns ERROR then OK -> two complete 4-symbol bursts, single done with result=0.
